// File: rtl/latch_wr_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
package latch_wr_pkg;

    // Write sequence phases; IDLE is the only state that accepts requests.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } wr_state_t;

    // Address width for a bank of n words, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/latch_bank_writer_phase_timer.sv
// Loadable down-counter that times one sequencer phase. Loading value N-1
// makes the phase last N cycles; last is high on the final cycle.
module phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of gated D latches: captures a request, drives
// the shared D bus, then pulses the addressed gate with setup/hold margins.
// Optional readback check enabled by defining LATCH_WRITE_VERIFY_EN.
module latch_bank_writer
    import latch_wr_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  NUM_LATCH = 4,
    parameter int  SETUP_CYC = 1,
    parameter int  PULSE_CYC = 2,
    parameter int  HOLD_CYC  = 1,
    localparam int ADDR_W    = clog2_min1(NUM_LATCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic [DATA_W-1:0]    d_out,
    output logic [NUM_LATCH-1:0] g_out,
    output logic                 done,
    output logic                 addr_err,
    input  logic [DATA_W-1:0]    q_in,
    output logic                 verify_err
);

    localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [ADDR_W:0]  NUM_LATCH_W = (ADDR_W + 1)'(NUM_LATCH);

    // A zero-length gate pulse would never write anything.
    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("latch_bank_writer: PULSE_CYC must be at least 1");
    end

    wr_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     d_out_q, d_out_d;
    logic [NUM_LATCH-1:0]  g_out_q, g_out_d;
    logic                  req_ready_q, req_ready_d;
    logic                  done_q, done_d;
    logic                  addr_err_q, addr_err_d;
    logic                  verify_err_q, verify_err_d;

    logic                  accept;
    logic                  finish;
    logic                  addr_ok;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  phase_last;
    logic [NUM_LATCH-1:0]  gate_sel;

    assign accept  = (state_q == IDLE) && req_valid;
    assign finish  = (state_q != IDLE) && (state_d == IDLE);
    assign addr_ok = ({1'b0, addr_q} < NUM_LATCH_W);

    // Gate decode uses the address being captured so that a zero-setup
    // sequence can raise the gate on the very first busy cycle.
    for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_dec
        assign gate_sel[gi] = (addr_d == ADDR_W'(gi));
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (phase_last)
    );

    // Phase sequencing; zero-length SETUP/HOLD phases are skipped entirely.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tmr_load = 1'b1;
                    if (SETUP_CYC > 0) begin
                        state_d = SETUP;
                        tmr_val = SETUP_LD;
                    end else begin
                        state_d = PULSE;
                        tmr_val = PULSE_LD;
                    end
                end
            end
            SETUP: begin
                if (phase_last) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (phase_last) begin
                    if (HOLD_CYC > 0) begin
                        state_d  = HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (phase_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and capture values for the next cycle, all derived from state_d
    // so that every output leaves a flop.
    always_comb begin
        addr_d  = addr_q;
        d_out_d = d_out_q;
        if (accept) begin
            addr_d  = req_addr;
            d_out_d = req_data;
        end
        g_out_d     = (state_d == PULSE) ? gate_sel : '0;
        req_ready_d = (state_d == IDLE);
        done_d      = finish;
        addr_err_d  = finish && !addr_ok;
`ifdef LATCH_WRITE_VERIFY_EN
        // q_in is sampled on the last busy cycle, after the gate has closed
        // (or on the last gate cycle when there is no hold phase).
        verify_err_d = finish && addr_ok && (q_in != d_out_q);
`else
        verify_err_d = 1'b0;
`endif
    end

`ifndef LATCH_WRITE_VERIFY_EN
    logic unused_q_in;
    assign unused_q_in = ^q_in;
`endif

    // State and output registers; reset drops the gate immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            d_out_q      <= '0;
            g_out_q      <= '0;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            d_out_q      <= d_out_d;
            g_out_q      <= g_out_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            addr_err_q   <= addr_err_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign d_out      = d_out_q;
    assign g_out      = g_out_q;
    assign done       = done_q;
    assign addr_err   = addr_err_q;
    assign verify_err = verify_err_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: three instances (default timing, minimal
// timing with a stuck-bit latch model, 3-word bank) driven from a vector
// table plus hand-written timing, back-to-back, range and reset sequences.
`timescale 1ns/1ps
module tb_latch_bank_writer;

`ifdef LATCH_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: defaults. B: SETUP=0 PULSE=1 HOLD=0. C: NUM_LATCH=3.
    logic       rv_a, rv_b, rv_c;
    logic [1:0] ra_a, ra_b, ra_c;
    logic [7:0] rd_a, rd_b, rd_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] do_a, do_b, do_c;
    logic [3:0] g_a, g_b;
    logic [2:0] g_c;
    logic       done_a, done_b, done_c;
    logic       aerr_a, aerr_b, aerr_c;
    logic       verr_a, verr_b, verr_c;
    logic [7:0] q_a, q_b, q_c;

    latch_bank_writer u_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rdy_a), .req_addr(ra_a),
        .req_data(rd_a), .d_out(do_a), .g_out(g_a), .done(done_a), .addr_err(aerr_a),
        .q_in(q_a), .verify_err(verr_a));

    latch_bank_writer #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rdy_b), .req_addr(ra_b),
        .req_data(rd_b), .d_out(do_b), .g_out(g_b), .done(done_b), .addr_err(aerr_b),
        .q_in(q_b), .verify_err(verr_b));

    latch_bank_writer #(.NUM_LATCH(3)) u_c (
        .clk(clk), .rst(rst), .req_valid(rv_c), .req_ready(rdy_c), .req_addr(ra_c),
        .req_data(rd_c), .d_out(do_c), .g_out(g_c), .done(done_c), .addr_err(aerr_c),
        .q_in(q_c), .verify_err(verr_c));

    // Behavioural latch banks; B has data bit 0 stuck at zero.
    logic [7:0] lat_a [4];
    logic [7:0] lat_b [4];
    logic [7:0] lat_c [4];
    logic [1:0] cur_a, cur_b, cur_c;

    always @(g_a or do_a) for (int i = 0; i < 4; i++) if (g_a[i]) lat_a[i] = do_a;
    always @(g_b or do_b) for (int i = 0; i < 4; i++) if (g_b[i]) lat_b[i] = do_b & 8'hFE;
    always @(g_c or do_c) for (int i = 0; i < 3; i++) if (g_c[i]) lat_c[i] = do_c;

    assign q_a = lat_a[cur_a];
    assign q_b = lat_b[cur_b];
    assign q_c = lat_c[cur_c];

    // Per-instance views for the monitor.
    logic [3:0] g_v    [3];
    logic [7:0] dout_v [3];
    logic       rdy_v  [3];
    logic       done_v [3];
    logic       aerr_v [3];
    logic       verr_v [3];

    assign g_v[0] = g_a;          assign g_v[1] = g_b;          assign g_v[2] = {1'b0, g_c};
    assign dout_v[0] = do_a;      assign dout_v[1] = do_b;      assign dout_v[2] = do_c;
    assign rdy_v[0] = rdy_a;      assign rdy_v[1] = rdy_b;      assign rdy_v[2] = rdy_c;
    assign done_v[0] = done_a;    assign done_v[1] = done_b;    assign done_v[2] = done_c;
    assign aerr_v[0] = aerr_a;    assign aerr_v[1] = aerr_b;    assign aerr_v[2] = aerr_c;
    assign verr_v[0] = verr_a;    assign verr_v[1] = verr_b;    assign verr_v[2] = verr_c;

    typedef struct {
        int         sel;
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] exp_g;
        logic       exp_aerr;
        logic       exp_verr;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic [3:0] g;
        logic       aerr;
        logic       verr;
        int         pulses;
        int         busy;
    } exp_t;

    exp_t sb[$];
    int   gcnt [3];
    int   bcnt [3];
    int   acc_cyc;

    function automatic int busy_of(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic int pulse_of(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard side: compare gates every cycle, and the completed write on done.
    task automatic mon(input int k);
        int   idx[$];
        exp_t e;
        if (rst) begin
            gcnt[k] = 0;
            bcnt[k] = 0;
            return;
        end
        idx = sb.find_first_index(x) with (x.sel == k);
        if (!rdy_v[k]) bcnt[k]++;
        if (g_v[k] != 4'd0) begin
            gcnt[k]++;
            if (idx.size() == 0) chk($sformatf("dut%0d gate without write", k), int'(g_v[k]), 0);
            else chk($sformatf("dut%0d g_out", k), int'(g_v[k]), int'(sb[idx[0]].g));
        end
        if (!done_v[k]) begin
            chk($sformatf("dut%0d stray err pulse", k), int'({aerr_v[k], verr_v[k]}), 0);
        end else if (idx.size() == 0) begin
            chk($sformatf("dut%0d unexpected done", k), 1, 0);
        end else begin
            e = sb[idx[0]];
            sb.delete(idx[0]);
            chk($sformatf("dut%0d d_out at done", k), int'(dout_v[k]), int'(e.d));
            chk($sformatf("dut%0d addr_err", k), int'(aerr_v[k]), int'(e.aerr));
            chk($sformatf("dut%0d verify_err", k), int'(verr_v[k]), int'(e.verr));
            chk($sformatf("dut%0d gate cycles", k), gcnt[k], e.pulses);
            chk($sformatf("dut%0d busy cycles", k), bcnt[k], e.busy);
            $display("dut%0d write d=%02h aerr=%0b verr=%0b gate_cyc=%0d busy=%0d", k,
                     dout_v[k], aerr_v[k], verr_v[k], gcnt[k], bcnt[k]);
            gcnt[k] = 0;
            bcnt[k] = 0;
        end
    endtask

    always @(negedge clk) for (int k = 0; k < 3; k++) mon(k);

    task automatic set_valid(input int k, input logic v);
        case (k)
            0: rv_a = v;
            1: rv_b = v;
            default: rv_c = v;
        endcase
    endtask

    // Present a request, wait for acceptance and push its expected outcome.
    task automatic send(input int k, input logic [1:0] a, input logic [7:0] d, input bit keep,
                        input logic [3:0] eg, input logic ea, input logic ev);
        int   n;
        exp_t e;
        @(negedge clk);
        rv_a = 1'b0; rv_b = 1'b0; rv_c = 1'b0;
        set_valid(k, 1'b1);
        case (k)
            0: begin ra_a = a; rd_a = d; end
            1: begin ra_b = a; rd_b = d; end
            default: begin ra_c = a; rd_c = d; end
        endcase
        n = 0;
        while (!rdy_v[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_v[k]) begin
            chk($sformatf("dut%0d accept timeout", k), 0, 1);
            set_valid(k, 1'b0);
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        e.sel = k; e.d = d; e.g = eg; e.aerr = ea; e.verr = ev;
        e.pulses = ea ? 0 : pulse_of(k);
        e.busy = busy_of(k);
        sb.push_back(e);
        case (k)
            0: cur_a = a;
            1: cur_b = a;
            default: cur_c = a;
        endcase
        if (!keep) set_valid(k, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", sb.size(), 0);
    endtask

    vec_t vt [10];

    initial begin
        int t1;
        int idx[$];
        int eg [5];
        int er [5];
        int ed [5];

        rst = 1'b1;
        rv_a = 0; rv_b = 0; rv_c = 0;
        ra_a = 0; ra_b = 0; ra_c = 0;
        rd_a = 0; rd_b = 0; rd_c = 0;
        cur_a = 0; cur_b = 0; cur_c = 0;

        vt[0] = '{0, 2'd0, 8'h11, 4'b0001, 1'b0, 1'b0};
        vt[1] = '{0, 2'd1, 8'h3C, 4'b0010, 1'b0, 1'b0};
        vt[2] = '{0, 2'd3, 8'hFF, 4'b1000, 1'b0, 1'b0};
        vt[3] = '{1, 2'd2, 8'h5A, 4'b0100, 1'b0, 1'b0};
        vt[4] = '{1, 2'd1, 8'h81, 4'b0010, 1'b0, VERIFY};
        vt[5] = '{1, 2'd0, 8'hFF, 4'b0001, 1'b0, VERIFY};
        vt[6] = '{2, 2'd3, 8'h77, 4'b0000, 1'b1, 1'b0};
        vt[7] = '{2, 2'd2, 8'hC3, 4'b0100, 1'b0, 1'b0};
        vt[8] = '{2, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0};
        vt[9] = '{0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0};

        // Reset state of all three instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d reset d_out", k), int'(dout_v[k]), 0);
            chk($sformatf("dut%0d reset g_out", k), int'(g_v[k]), 0);
            chk($sformatf("dut%0d reset done", k), int'(done_v[k]), 0);
            chk($sformatf("dut%0d reset req_ready", k), int'(rdy_v[k]), 1);
        end
        rst = 1'b0;

        // Default timing, cycle by cycle after the accept edge.
        eg = '{0, 4, 4, 0, 0};
        er = '{0, 0, 0, 0, 1};
        ed = '{0, 0, 0, 0, 1};
        send(0, 2'd2, 8'hA5, 1'b0, 4'b0100, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("timing c%0d g_out", c + 1), int'(g_a), eg[c]);
            chk($sformatf("timing c%0d req_ready", c + 1), int'(rdy_a), er[c]);
            chk($sformatf("timing c%0d done", c + 1), int'(done_a), ed[c]);
            chk($sformatf("timing c%0d d_out", c + 1), int'(do_a), 8'hA5);
        end

        // Minimal timing: gate the cycle after accept, done the cycle after.
        send(1, 2'd2, 8'h5A, 1'b0, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("fast g_out", int'(g_b), 4'b0100);
        chk("fast done early", int'(done_b), 0);
        @(negedge clk);
        chk("fast g_out after", int'(g_b), 0);
        chk("fast done", int'(done_b), 1);

        // Back-to-back with valid held: second accept lands in the done cycle.
        send(0, 2'd1, 8'h3C, 1'b1, 4'b0010, 1'b0, 1'b0);
        t1 = acc_cyc;
        send(0, 2'd3, 8'hFF, 1'b0, 4'b1000, 1'b0, 1'b0);
        chk("back-to-back accept spacing", acc_cyc - t1, 5);

        // Out-of-range address on the 3-word bank.
        send(2, 2'd3, 8'h77, 1'b0, 4'b0000, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("oor g_out", int'(g_c), 0);
            if (done_c) begin
                chk("oor addr_err with done", int'(aerr_c), 1);
                break;
            end
        end
        drain();

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            send(vt[i].sel, vt[i].addr, vt[i].data,
                 (i < 9) && (vt[i + 1].sel == vt[i].sel),
                 vt[i].exp_g, vt[i].exp_aerr, vt[i].exp_verr);
        end
        drain();

        // Reset during the second gate cycle abandons the write.
        send(0, 2'd2, 8'h96, 1'b0, 4'b0100, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset g_out", int'(g_a), 4'b0100);
        rst = 1'b1;
        #1;
        chk("async reset g_out", int'(g_a), 0);
        chk("async reset req_ready", int'(rdy_a), 1);
        idx = sb.find_index(x) with (x.sel == 0);
        for (int j = idx.size() - 1; j >= 0; j--) sb.delete(idx[j]);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no done after reset", int'(done_a), 0);
        end
        send(0, 2'd1, 8'h42, 1'b0, 4'b0010, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/latch_bank_writer.md
Name: latch_bank_writer

Overview:
- Initiator-side sequencer that drives the D/G inputs of a bank of gated D latches.
- Accepts a write request (address + data) on a valid/ready handshake.
- Drives the data bus, then asserts the addressed latch's gate for a programmed number of cycles, with guaranteed setup and hold time around the pulse.
- Sits between synchronous control logic and latch-based storage; it is the only agent allowed to toggle G.

Parameters:
- DATA_W, 8, width of data bus driven to every latch D input.
- NUM_LATCH, 4, number of latch words in the bank; ADDR_W = $clog2(NUM_LATCH), minimum 1.
- SETUP_CYC, 1, cycles D is stable before G rises (0 allowed).
- PULSE_CYC, 2, cycles G is high (must be >= 1; elaboration error otherwise).
- HOLD_CYC, 1, cycles D is held after G falls (0 allowed).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request present.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  target latch word.
- req_data  in  DATA_W  value to store.
- d_out  out  DATA_W  shared D bus to all latch words.
- g_out  out  NUM_LATCH  one-hot gate enables, at most one bit high.
- done  out  1  one-cycle pulse when a write completes.
- addr_err  out  1  one-cycle pulse, coincident with done, if the address was out of range.
- q_in  in  DATA_W  Q of the addressed word (muxed externally); used only with the optional feature.
- verify_err  out  1  one-cycle pulse, coincident with done, on readback mismatch.

Behaviour:
- Reset (async, immediate): state=IDLE; d_out=0, g_out=0, done=0, addr_err=0, verify_err=0, req_ready=1 once in IDLE. Reset mid-pulse drops g_out to 0 asynchronously; the in-flight write is abandoned and no done is issued.
- Handshake: the transfer occurs on the edge where req_valid && req_ready. addr/data are captured into registers, and d_out loads req_data on that same edge. Inputs are ignored outside IDLE.
- FSM is IDLE -> SETUP -> PULSE -> HOLD -> IDLE. A state whose count is 0 is skipped, e.g. IDLE->PULSE when SETUP_CYC=0 and PULSE->IDLE when HOLD_CYC=0.
- Each state lasts exactly its *_CYC cycles, counted by a down-counter loaded on entry.
- g_out[addr] is high exactly in PULSE cycles; all g_out bits are 0 in every other state.
- d_out holds the captured data in SETUP, PULSE and HOLD. It keeps its last value in IDLE and changes only at the next accept.
- done is registered and goes high on the first IDLE cycle after a write. Busy time is SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, and req_ready=1 during the done cycle.
- Back-to-back: a request presented during the done cycle is accepted on that edge, leaving no idle gap beyond the done cycle.
- Out-of-range address (addr >= NUM_LATCH, non-power-of-2 banks): full timing sequence runs, g_out stays 0, and addr_err pulses with done.
- All outputs are registered; g_out is glitch-free.

Optional Feature:
- Macro: LATCH_WRITE_VERIFY_EN.
- Defined: q_in is sampled on the last cycle before returning to IDLE, i.e. the last HOLD cycle, or the last PULSE cycle if HOLD_CYC=0. verify_err pulses with done if the sample != captured data. Not checked when addr_err is set.
- Undefined: q_in is ignored and verify_err is tied 0. Port list is unchanged.

Decomposition:
- Package latch_wr_pkg: state enum type (IDLE, SETUP, PULSE, HOLD) and a function clog2_min1 for ADDR_W.
- One sub-module, phase_timer: loadable down-counter of width $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1) with a last-cycle flag, instantiated once.

Test Plan:
- Defaults, write addr=2 data=0xA5 -> d_out=0xA5 from the accept edge; g_out=4'b0100 for exactly 2 cycles after 1 setup cycle; d_out still 0xA5 in the 1 hold cycle; done on cycle 5; req_ready low cycles 1-4.
- SETUP_CYC=0, HOLD_CYC=0, PULSE_CYC=1 -> g_out high the cycle after accept; done the following cycle.
- Back-to-back: writes (1,0x3C) then (3,0xFF) with req_valid held -> second accepted in the done cycle; g_out never has two bits set; no gap between sequences.
- NUM_LATCH=3, addr=3 -> g_out stays 000 for the whole sequence; addr_err and done pulse together.
- rst asserted in the 2nd PULSE cycle -> g_out=0 immediately (before the next edge); no done; the next request after release completes normally.
- With LATCH_WRITE_VERIFY_EN and a behavioural latch model (one bit stuck at 0), write 0xFF -> verify_err=1 with done; a healthy model gives verify_err=0.
